// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: rotate, ping-pong, blink, breathe (PWM).
// Latency: one clock from internal state (pat / pwm compare) to registered led; step_tick registered from prescaler terminal count.
// Backpressure: none; en=0 freezes all pattern state and blanks the LEDs, a mode change re-initialises and wins over en.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-high (async assert, sync release expected from the board)
//   en         1 = run, 0 = freeze state and drive LEDs dark
//   mode       0 rotate, 1 ping-pong, 2 blink, 3 breathe
//   led        LED drive, 1 = lit, registered
//   step_tick  one-clock pulse per pattern step, registered
//
// Build option: define LED_BREATHE_EN to build the breathe (PWM) engine.
// Without it, mode 3 behaves exactly like mode 0 rotate.

module led_pattern_gen #(
    parameter int LED_W      = 8,
    parameter int STEP_CNT   = 25_000_000,
    parameter int PWM_W      = 8,
    parameter int BREATH_DIV = 380
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             step_tick
);

    localparam int CNT_W = $clog2(STEP_CNT);

    localparam logic [1:0] MODE_ROTATE   = 2'd0;
    localparam logic [1:0] MODE_PINGPONG = 2'd1;
    localparam logic [1:0] MODE_BLINK    = 2'd2;
    localparam logic [1:0] MODE_BREATHE  = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Elaboration-time guard on the parameter ranges the logic relies on.
    if (LED_W < 2 || STEP_CNT < 2 || PWM_W < 2 || BREATH_DIV < 1) begin : g_bad_param
        $error("led_pattern_gen: parameter out of range");
    end

    logic [CNT_W-1:0] cnt;
    logic [LED_W-1:0] pat;
    logic             dir;
    logic [1:0]       mode_q;

    logic             reinit;
    logic             step;
    logic [LED_W-1:0] pat_nxt;
    logic             dir_nxt;
    logic [LED_W-1:0] pat_init;
    logic [LED_W-1:0] disp;

    // A mode change restarts everything from a clean pattern; it is checked
    // before en so the new mode always starts from its defined initial state.
    assign reinit   = (mode != mode_q);
    assign step     = (cnt == CNT_W'(STEP_CNT - 1));
    assign pat_init = (mode == MODE_BLINK) ? {LED_W{1'b1}} : LED_W'(1);

    // Pattern advance for one step in the current mode. Breathe (and mode 3
    // in builds without the PWM engine) falls into the rotate branch.
    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir;
        case (mode_q)
            MODE_PINGPONG: begin
                // Reverse at an end LED within the same step, so end LEDs
                // are shown for a single step only.
                if (dir == DIR_UP) begin
                    if (pat[LED_W-1]) begin
                        dir_nxt = DIR_DOWN;
                        pat_nxt = pat >> 1;
                    end else begin
                        pat_nxt = pat << 1;
                    end
                end else begin
                    if (pat[0]) begin
                        dir_nxt = DIR_UP;
                        pat_nxt = pat << 1;
                    end else begin
                        pat_nxt = pat >> 1;
                    end
                end
            end
            MODE_BLINK: begin
                pat_nxt = ~pat;
            end
            default: begin
                pat_nxt = {pat[LED_W-2:0], pat[LED_W-1]};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            pat       <= LED_W'(1);
            dir       <= DIR_UP;
            mode_q    <= MODE_ROTATE;
            step_tick <= 1'b0;
        end else begin
            mode_q <= mode;
            if (reinit) begin
                cnt       <= '0;
                pat       <= pat_init;
                dir       <= DIR_UP;
                step_tick <= 1'b0;
            end else if (en) begin
                cnt       <= step ? '0 : cnt + CNT_W'(1);
                step_tick <= step;
                if (step) begin
                    pat <= pat_nxt;
                    dir <= dir_nxt;
                end
            end else begin
                step_tick <= 1'b0;
            end
        end
    end

`ifdef LED_BREATHE_EN
    localparam int BDIV_W = $clog2(BREATH_DIV + 1);

    logic [PWM_W-1:0]  pwm_cnt;
    logic [PWM_W-1:0]  duty;
    logic              ddir;
    logic [BDIV_W-1:0] bdiv;
    logic              pwm_wrap;
    logic              bdiv_last;

    assign pwm_wrap  = (pwm_cnt == {PWM_W{1'b1}});
    assign bdiv_last = (bdiv == BDIV_W'(BREATH_DIV - 1));

    // Duty ramps up and down by one every BREATH_DIV PWM periods. At either
    // end the update only turns the ramp around, so the extreme duty is held
    // for two ramp intervals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
            ddir    <= DIR_UP;
            bdiv    <= '0;
        end else if (reinit) begin
            pwm_cnt <= '0;
            duty    <= '0;
            ddir    <= DIR_UP;
            bdiv    <= '0;
        end else if (en && mode_q == MODE_BREATHE) begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (pwm_wrap) begin
                if (bdiv_last) begin
                    bdiv <= '0;
                    if (ddir == DIR_UP) begin
                        if (duty == {PWM_W{1'b1}}) begin
                            ddir <= DIR_DOWN;
                        end else begin
                            duty <= duty + PWM_W'(1);
                        end
                    end else begin
                        if (duty == '0) begin
                            ddir <= DIR_UP;
                        end else begin
                            duty <= duty - PWM_W'(1);
                        end
                    end
                end else begin
                    bdiv <= bdiv + BDIV_W'(1);
                end
            end
        end
    end

    assign disp = (mode_q == MODE_BREATHE) ? {LED_W{(pwm_cnt < duty)}} : pat;
`else
    assign disp = pat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= en ? disp : '0;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (LED_W=4, STEP_CNT=4, PWM_W=3, BREATH_DIV=2).
// The stimulus process pushes the hand-derived {led, step_tick} expected after
// each clock; a negedge monitor pops and compares.

module tb_led_pattern_gen;

    localparam int LED_W      = 4;
    localparam int STEP_CNT   = 4;
    localparam int PWM_W      = 3;
    localparam int BREATH_DIV = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [LED_W-1:0] led;
    logic             step_tick;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .LED_W      (LED_W),
        .STEP_CNT   (STEP_CNT),
        .PWM_W      (PWM_W),
        .BREATH_DIV (BREATH_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .led        (led),
        .step_tick  (step_tick)
    );

    typedef struct packed {
        logic [7:0]  sc;
        logic [15:0] idx;
        logic [3:0]  led;
        logic        tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   sc    = 0;
    int   vidx  = 0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got led=%b tick=%b, expected led=%b tick=%b",
                     name, act[4:1], act[0], req[4:1], req[0]);
        end
    endtask

    // Monitor: one expected entry per clock, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("s%0d_v%0d", e.sc, e.idx), {led, step_tick}, {e.led, e.tick});
        end
    end

    // Drive one clock of inputs, then queue what the DUT must show after that edge.
    task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] el, input logic et);
        exp_t x;
        rst  = r;
        en   = e;
        mode = m;
        @(posedge clk);
        #1;
        x.sc   = sc[7:0];
        x.idx  = vidx[15:0];
        x.led  = el;
        x.tick = et;
        exp_q.push_back(x);
        vidx++;
    endtask

    // One full pattern step: value held 4 clocks, tick on the last.
    task automatic blk(input logic [1:0] m, input logic [3:0] v);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, m, v, 1'b0);
        cyc(1'b0, 1'b1, m, v, 1'b1);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        mode = 2'd0;

        // 0: reset held 3 clocks, outputs dark
        sc = 0;
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);

        // 1: rotate from reset
        sc = 1;
        blk(2'd0, 4'b0001);
        blk(2'd0, 4'b0010);
        blk(2'd0, 4'b0100);
        blk(2'd0, 4'b1000);
        blk(2'd0, 4'b0001);

        // 2: ping-pong, 10 steps; re-init clock still shows old pattern 0010
        sc = 2;
        cyc(1'b0, 1'b1, 2'd1, 4'b0010, 1'b0);
        blk(2'd1, 4'b0001);
        blk(2'd1, 4'b0010);
        blk(2'd1, 4'b0100);
        blk(2'd1, 4'b1000);
        blk(2'd1, 4'b0100);
        blk(2'd1, 4'b0010);
        blk(2'd1, 4'b0001);
        blk(2'd1, 4'b0010);
        blk(2'd1, 4'b0100);
        blk(2'd1, 4'b1000);

        // 3: rotate for 2 clocks, then switch to blink mid-step
        sc = 3;
        cyc(1'b0, 1'b1, 2'd0, 4'b0100, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, 4'b0001, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, 4'b0001, 1'b0);
        cyc(1'b0, 1'b1, 2'd2, 4'b0001, 1'b0);
        blk(2'd2, 4'b1111);
        blk(2'd2, 4'b0000);
        blk(2'd2, 4'b1111);
        blk(2'd2, 4'b0000);

        // 4: rotate, freeze at 0100 two clocks into the step, resume
        sc = 4;
        cyc(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0);
        blk(2'd0, 4'b0001);
        blk(2'd0, 4'b0010);
        cyc(1'b0, 1'b1, 2'd0, 4'b0100, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, 4'b0100, 1'b0);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, 4'b0100, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, 4'b0100, 1'b1);
        blk(2'd0, 4'b1000);

        // 5: mode 3
        sc = 5;
        cyc(1'b0, 1'b1, 2'd3, 4'b0001, 1'b0);
`ifdef LED_BREATHE_EN
        // 16-clock windows: duty 0..7, 7 again (turnaround), then 6,5,4;
        // LEDs lit for the first duty clocks of each 8-clock PWM period.
        for (int i = 1; i <= 192; i++) begin
            int w;
            int j;
            int d;
            w = (i - 1) / 16;
            j = (i - 1) % 16;
            d = (w <= 7) ? w : 15 - w;
            cyc(1'b0, 1'b1, 2'd3, ((j % 8) < d) ? 4'b1111 : 4'b0000, (i % 4) == 0);
        end
`else
        blk(2'd3, 4'b0001);
        blk(2'd3, 4'b0010);
        blk(2'd3, 4'b0100);
        blk(2'd3, 4'b1000);
        blk(2'd3, 4'b0001);
`endif

        // 6: ping-pong, async reset mid-step, release into ping-pong
        sc = 6;
`ifdef LED_BREATHE_EN
        cyc(1'b0, 1'b1, 2'd1, 4'b1111, 1'b0);
`else
        cyc(1'b0, 1'b1, 2'd1, 4'b0010, 1'b0);
`endif
        blk(2'd1, 4'b0001);
        blk(2'd1, 4'b0010);
        cyc(1'b0, 1'b1, 2'd1, 4'b0100, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 4'b0100, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_no_clk", {led, step_tick}, 5'b0000_0);
        cyc(1'b1, 1'b1, 2'd1, 4'b0000, 1'b0);
        cyc(1'b1, 1'b1, 2'd1, 4'b0000, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 4'b0001, 1'b0);
        blk(2'd1, 4'b0001);
        blk(2'd1, 4'b0010);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
